// File: rtl/oped_axil_arbiter.sv
// oped_axil_arbiter: round-robin share of one AXI4-Lite master between two requesters, one transaction in flight.
// Optional response watchdog enabled by defining OPED_AXIL_TIMEOUT_EN.
module oped_axil_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [1:0]  REQ,
  input  logic [1:0]  REQ_WE,
  input  logic [63:0] REQ_ADDR,
  input  logic [63:0] REQ_WDATA,
  input  logic [7:0]  REQ_WSTRB,
  output logic [1:0]  ACK,
  output logic [31:0] ACK_RDATA,
  output logic [1:0]  ACK_RESP,
  output logic [1:0]  GRANT,
  output logic        TIMEOUT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_AWADDR,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  input  logic [1:0]  M_AXI_BRESP,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic [2:0]  M_AXI_ARPROT,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP
);
  typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;
  state_t state_q, state_d;
  logic        we_q, we_d, last_q, last_d, pick;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ack_rdata_q, ack_rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  grant_q, grant_d, ack_q, ack_d, ack_resp_q, ack_resp_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic        bready_q, bready_d, rready_q, rready_d;
`ifdef OPED_AXIL_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`endif
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    grant_d    = grant_q;
    ack_d      = 2'b00;
    ack_rdata_d = ack_rdata_q;
    ack_resp_d = ack_resp_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    bready_d   = bready_q;
    rready_d   = rready_q;
    // requester 1 wins when alone, or when both ask and 0 went last
    pick       = REQ[1] & (~REQ[0] | ~last_q);
`ifdef OPED_AXIL_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
`endif
    if (state_q == IDLE) begin
      if (|REQ) begin
        we_d      = pick ? REQ_WE[1] : REQ_WE[0];
        addr_d    = pick ? REQ_ADDR[63:32] : REQ_ADDR[31:0];
        wdata_d   = pick ? REQ_WDATA[63:32] : REQ_WDATA[31:0];
        wstrb_d   = pick ? REQ_WSTRB[7:4] : REQ_WSTRB[3:0];
        grant_d   = pick ? 2'b10 : 2'b01;
        last_d    = pick;
        awvalid_d = we_d;
        wvalid_d  = we_d;
        arvalid_d = ~we_d;
        state_d   = ADDR;
`ifdef OPED_AXIL_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
    end else if (state_q == ADDR) begin
      if (we_q) begin
        awvalid_d = awvalid_q & ~M_AXI_AWREADY;
        wvalid_d  = wvalid_q & ~M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = RESP;
        end
      end else if (M_AXI_ARREADY) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RESP;
      end
    end else if (state_q == RESP) begin
      if (we_q ? M_AXI_BVALID : M_AXI_RVALID) begin
        bready_d    = 1'b0;
        rready_d    = 1'b0;
        ack_d       = grant_q;
        ack_resp_d  = we_q ? M_AXI_BRESP : M_AXI_RRESP;
        ack_rdata_d = we_q ? 32'd0 : M_AXI_RDATA;
        state_d     = DONE;
      end
    end else begin
      grant_d = 2'b00;
      state_d = IDLE;
    end
`ifdef OPED_AXIL_TIMEOUT_EN
    if (state_q == ADDR || state_q == RESP) begin
      cnt_d = cnt_q + 32'd1;
      if (cnt_d == TIMEOUT_CYCLES && state_d != DONE) begin
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        arvalid_d   = 1'b0;
        bready_d    = 1'b0;
        rready_d    = 1'b0;
        ack_d       = grant_q;
        ack_resp_d  = 2'b10;
        ack_rdata_d = 32'hDEAD_C0DE;
        timeout_d   = 1'b1;
        state_d     = DONE;
      end
    end
`endif
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      last_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      ack_rdata_q <= '0;
      ack_resp_q  <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
`ifdef OPED_AXIL_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      ack_rdata_q <= ack_rdata_d;
      ack_resp_q  <= ack_resp_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
`ifdef OPED_AXIL_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end
`ifdef OPED_AXIL_TIMEOUT_EN
  assign TIMEOUT = timeout_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign TIMEOUT = 1'b0;
`endif
  assign ACK           = ack_q;
  assign ACK_RDATA     = ack_rdata_q;
  assign ACK_RESP      = ack_resp_q;
  assign GRANT         = grant_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_oped_axil_arbiter.sv
// tb_oped_axil_arbiter: directed checks of grant order, latency, handshake ordering, reset and watchdog.
module tb_oped_axil_arbiter;
  logic        ACLK, ARESET;
  logic [1:0]  REQ, REQ_WE, ACK, ACK_RESP, GRANT;
  logic [63:0] REQ_ADDR, REQ_WDATA;
  logic [7:0]  REQ_WSTRB;
  logic [31:0] ACK_RDATA;
  logic        TIMEOUT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BREADY;
  logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  int tests = 0, fails = 0, viol = 0, n;
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0;
  logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
  logic [31:0] r_data = 32'h0;

  oped_axil_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB), .ACK(ACK), .ACK_RDATA(ACK_RDATA),
    .ACK_RESP(ACK_RESP), .GRANT(GRANT), .TIMEOUT(TIMEOUT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWADDR(M_AXI_AWADDR),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // slave model: each READY/VALID appears after its configured number of extra wait cycles
  always @(negedge ACLK) begin
    aw_n = M_AXI_AWVALID ? aw_n + 1 : 0;
    w_n  = M_AXI_WVALID ? w_n + 1 : 0;
    ar_n = M_AXI_ARVALID ? ar_n + 1 : 0;
    b_n  = M_AXI_BREADY ? b_n + 1 : 0;
    r_n  = M_AXI_RREADY ? r_n + 1 : 0;
    M_AXI_AWREADY = M_AXI_AWVALID && aw_n > aw_wait;
    M_AXI_WREADY  = M_AXI_WVALID && w_n > w_wait;
    M_AXI_ARREADY = M_AXI_ARVALID && ar_n > ar_wait;
    M_AXI_BVALID  = M_AXI_BREADY && b_n > b_wait;
    M_AXI_RVALID  = M_AXI_RREADY && r_n > r_wait;
    M_AXI_BRESP   = b_resp;
    M_AXI_RRESP   = r_resp;
    M_AXI_RDATA   = r_data;
    if ((M_AXI_AWVALID || M_AXI_WVALID) && M_AXI_ARVALID) viol++;
    if (GRANT == 2'b11 || M_AXI_AWPROT != 3'b000 || M_AXI_ARPROT != 3'b000) viol++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output int cyc, input logic [1:0] gexp);
    cyc = 0;
    do begin
      @(negedge ACLK);
      cyc++;
      if (gexp != 2'b00) chk("grant_hold", GRANT, gexp);
    end while (ACK == 2'b00 && cyc < 64);
  endtask

  initial begin
    ARESET = 1'b1; REQ = '0; REQ_WE = '0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_WSTRB = '0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0; M_AXI_BVALID = 0; M_AXI_RVALID = 0;
    M_AXI_BRESP = '0; M_AXI_RRESP = '0; M_AXI_RDATA = '0;
    repeat (3) @(negedge ACLK);
    chk("rst_grant", GRANT, 2'b00);
    chk("rst_ack", ACK, 2'b00);
    chk("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 5'b0);
    chk("rst_data", {M_AXI_AWADDR, M_AXI_WDATA}, 64'h0);
    chk("rst_ackdata", {ACK_RDATA, ACK_RESP, TIMEOUT}, 35'h0);
    ARESET = 1'b0;
    @(negedge ACLK);
    // requester 0 write, zero-wait slave
    REQ = 2'b01; REQ_WE = 2'b01; REQ_ADDR = {32'h0, 32'h0000_0010};
    REQ_WDATA = {32'h0, 32'hA5A5_0001}; REQ_WSTRB = 8'h0F;
    @(negedge ACLK);
    chk("w0_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 3'b110);
    chk("w0_awaddr", M_AXI_AWADDR, 32'h0000_0010);
    chk("w0_wdata", {M_AXI_WDATA, M_AXI_WSTRB}, {32'hA5A5_0001, 4'hF});
    chk("w0_grant", GRANT, 2'b01);
    @(negedge ACLK);
    chk("w0_resp_phase", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b001);
    @(negedge ACLK);
    chk("w0_ack_t3", ACK, 2'b01);
    chk("w0_ackresp", {ACK_RESP, ACK_RDATA}, 34'h0);
    REQ = 2'b00;
    @(negedge ACLK);
    chk("w0_done", {ACK, GRANT, M_AXI_BREADY}, 5'b0);
    // requester 1 read with ARREADY two cycles late
    REQ = 2'b10; REQ_WE = 2'b00; REQ_ADDR = {32'h0000_0020, 32'h0}; ar_wait = 2; r_data = 32'h1234_5678;
    wait_ack(n, 2'b10);
    chk("r1_lat", n, 5);
    chk("r1_ack", ACK, 2'b10);
    chk("r1_rdata", {ACK_RDATA, ACK_RESP}, {32'h1234_5678, 2'b00});
    chk("r1_araddr", M_AXI_ARADDR, 32'h0000_0020);
    REQ = 2'b00; ar_wait = 0;
    @(negedge ACLK);
    // both requesting: alternate owners, error responses passed through
    REQ = 2'b11; REQ_WE = 2'b01; REQ_ADDR = {32'h0000_0200, 32'h0000_0100};
    b_resp = 2'b10; r_resp = 2'b11; r_data = 32'h0BAD_F00D;
    for (int i = 0; i < 6; i++) begin
      wait_ack(n, 2'b00);
      chk("rr_grant", ACK, (i % 2) ? 2'b10 : 2'b01);
      if (i > 0) chk("rr_rate", n, 4);
      chk("rr_resp", {ACK_RESP, ACK_RDATA}, (i % 2) ? {2'b11, 32'h0BAD_F00D} : {2'b10, 32'h0});
    end
    REQ = 2'b00; b_resp = 2'b00; r_resp = 2'b00;
    @(negedge ACLK);
    // W accepted three cycles before AW
    REQ = 2'b01; REQ_WE = 2'b01; REQ_ADDR = {32'h0, 32'h0000_0030}; aw_wait = 3;
    @(negedge ACLK);
    chk("wf_both", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
    @(negedge ACLK);
    chk("wf_wdrop", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b10);
    wait_ack(n, 2'b01);
    chk("wf_lat", n + 2, 6);
    REQ = 2'b00; aw_wait = 0;
    @(negedge ACLK);
    chk("wf_single_ack", ACK, 2'b00);
    // reset while waiting for B
    b_wait = 1000; REQ = 2'b01; REQ_WE = 2'b01;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!M_AXI_BREADY && n < 20);
    chk("rst_in_resp", M_AXI_BREADY, 1'b1);
    REQ = 2'b00; ARESET = 1'b1;
    @(negedge ACLK);
    chk("rst_mid", {M_AXI_BREADY, GRANT, ACK, M_AXI_AWVALID, M_AXI_WVALID}, 7'b0);
    chk("rst_mid_data", {M_AXI_AWADDR, M_AXI_WSTRB}, 36'h0);
    ARESET = 1'b0; b_wait = 0; REQ = 2'b11; REQ_WE = 2'b00;
    @(negedge ACLK);
    chk("rst_first_grant", GRANT, 2'b01);
    wait_ack(n, 2'b00);
    chk("rst_first_ack", ACK, 2'b01);
    REQ = 2'b00;
    @(negedge ACLK);
`ifdef OPED_AXIL_TIMEOUT_EN
    b_wait = 1000; REQ = 2'b01; REQ_WE = 2'b01;
    wait_ack(n, 2'b01);
    chk("to_lat", n, 17);
    chk("to_resp", {ACK_RESP, ACK_RDATA}, {2'b10, 32'hDEAD_C0DE});
    chk("to_flag", TIMEOUT, 1'b1);
    REQ = 2'b00;
    @(negedge ACLK);
    chk("to_readies", {M_AXI_BREADY, M_AXI_AWVALID, M_AXI_WVALID}, 3'b0);
    b_wait = 0; REQ = 2'b01;
    wait_ack(n, 2'b01);
    chk("to_after_resp", ACK_RESP, 2'b00);
    chk("to_sticky", TIMEOUT, 1'b1);
    REQ = 2'b00;
    @(negedge ACLK);
`else
    repeat (20) @(negedge ACLK);
    chk("to_tied", TIMEOUT, 1'b0);
`endif
    chk("excl_valids", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
